// File: rtl/uart_hex_frame_tx.sv
// rtl/uart_hex_frame_tx.sv - latches a hex value and streams it as an ASCII frame to a byte UART
// Optional space grouping anchored at the LS digit, and optional CR/LF before or after the digits.
module uart_hex_frame_tx #(
    parameter int NIBBLES = 4,
    parameter int GROUP   = 2,
    parameter int EOL     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NIBBLES-1:0]   value,
    input  logic                   go,
    input  logic                   tx_ready,
    output logic [7:0]             tx_buf,
    output logic                   tx_start,
    output logic                   busy,
    output logic                   done
);

    localparam int GDIV   = (GROUP == 0) ? 1 : GROUP;
    localparam int SPACES = (GROUP == 0) ? 0 : (NIBBLES - 1) / GDIV;
    localparam int PRE    = (EOL == 2) ? 2 : 0;
    localparam int LEN    = NIBBLES + SPACES + ((EOL != 0) ? 2 : 0);

    typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

    state_t                 state;
    logic [5:0]             idx;
    logic [4*NIBBLES-1:0]   val_q;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Walks the frame layout to find which character sits at position idx.
    function automatic logic [7:0] char_at(input logic [5:0] i, input logic [4*NIBBLES-1:0] v);
        logic [7:0] c;
        int         pos;
        int         ii;
        c   = 8'h00;
        ii  = int'(i);
        pos = PRE;
        if (EOL == 2 && ii == 0) c = 8'h0D;
        if (EOL == 2 && ii == 1) c = 8'h0A;
        for (int j = NIBBLES - 1; j >= 0; j--) begin
            if (ii == pos) c = hex_char(v[4*j +: 4]);
            pos++;
            if (GROUP != 0 && j >= 1 && (j % GDIV) == 0) begin
                if (ii == pos) c = 8'h20;
                pos++;
            end
        end
        if (EOL == 1) begin
            if (ii == pos)     c = 8'h0D;
            if (ii == pos + 1) c = 8'h0A;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 6'd0;
            val_q    <= '0;
            tx_buf   <= 8'h00;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        val_q <= value;
                        busy  <= 1'b1;
                        idx   <= 6'd0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_buf   <= char_at(idx, val_q);
                        tx_start <= 1'b1;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    tx_start <= 1'b0;
                    // Ready dropping low is the transmitter taking the byte.
                    if (!tx_ready) begin
                        if (idx == 6'(LEN - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_hex_frame_tx.md
# uart_hex_frame_tx

Parametrised hex-to-ASCII framer that sits between a data source (keypad, register tap, debug counter) and the byte-wide UART transmitter. On a `go` pulse it latches a value of NIBBLES hex digits and streams it to the transmitter as an ASCII frame. The frame has optional digit grouping with spaces and optional CR/LF line termination, placed either before or after the digits. Each byte is handed over with a one-cycle `tx_start` strobe, paced by the transmitter's `tx_ready` level.

## Interface
- NIBBLES, 4, number of hex digits in `value` (1..16).
- GROUP, 2, digits per space-separated group; 0 disables spaces.
- EOL, 1, line-ending mode:
  - 0 = none.
  - 1 = CR LF appended after the digits.
  - 2 = CR LF prepended before the digits.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NIBBLES  data to print; sampled only on an accepted `go`.
- go  in  1  start request; accepted only when `busy`=0.
- tx_ready  in  1  transmitter idle/ready level (high = can take a byte).
- tx_buf  out  8  ASCII byte to transmit.
- tx_start  out  1  one-cycle strobe: transmit `tx_buf`.
- busy  out  1  high from accept until frame complete.
- done  out  1  one-cycle pulse when the last byte is acknowledged.

## Operation
- Reset values: `tx_buf`=0x00, `tx_start`=0, `busy`=0, `done`=0, state IDLE, index 0.
- Digit encoding:
  - Nibble 0-9 maps to 0x30+n.
  - Nibble A-F maps to 0x41+(n-10), uppercase.
  - Encoding is applied to the latched copy of `value`, never the live input.
- Frame order:
  - [CR 0x0D, LF 0x0A if EOL=2], then digits from most-significant nibble to least, then [CR, LF if EOL=1].
- Spaces:
  - Numbering digits by LS index j (NIBBLES-1 down to 0), a space (0x20) is emitted between digit j and digit j-1 whenever GROUP≠0 and j%GROUP==0, for j in 1..NIBBLES-1.
  - Grouping is therefore anchored at the LS end: NIBBLES=5, GROUP=2 gives "D DD DD".
- Frame length:
  - L = NIBBLES + S + (EOL≠0 ? 2 : 0).
  - S = (GROUP==0) ? 0 : (NIBBLES-1)/GROUP, integer division.
  - The character index counter must be wide enough for L (at most 16+15+2 = 33, so 6 bits).
- State machine:
  - IDLE:
    - If `go`=1, latch `value`, set `busy`=1, index=0, and go to SEND.
    - Otherwise stay.
  - SEND:
    - If `tx_ready`=1, register `tx_buf`=char(index) and `tx_start`=1, then go to ACK.
    - Otherwise hold with `tx_start`=0.
  - ACK:
    - `tx_start` returns to 0 after exactly one cycle.
    - Wait for `tx_ready`=0, which is the transmitter acknowledging the byte.
    - When it is seen: if index==L-1, go to IDLE with `busy`=0 and `done`=1 for one cycle; else index+1 and go to SEND.
- `tx_buf` holds the current byte from the `tx_start` cycle until the next byte is loaded. After the frame it keeps the last byte; it does not clear.
- `go` while `busy`=1 is ignored: no relatch and no restart.
- A `go` in the same cycle that `done` is high is accepted, because `busy` is already 0. The new frame starts with no idle gap.
- `rst` mid-frame: next cycle all outputs return to reset values. No `done` is produced and the partial frame is abandoned. `rst` overrides a coincident `go`.

## Timing
- `go` sampled at edge e0 → `busy`=1 after e0.
- First `tx_start` is high in the cycle after the first edge ≥ e1 at which `tx_ready`=1. Minimum latency from go to strobe is 2 edges.
- `tx_ready` sampled high at the strobe edge itself does not count as acknowledgement. Only a 0 sampled in ACK advances the frame.
- Per byte: one SEND cycle minimum, plus the ACK wait, plus the transmitter's busy time.
- `done` is high in the cycle after the final acknowledgement edge, coincident with `busy` falling.
- `tx_ready` stuck low in SEND, or stuck high in ACK, stalls indefinitely. There is no timeout.

## Test plan
- NIBBLES=4, GROUP=2, EOL=1, value=0xAB3F, UART model (ready drops 1 cycle after strobe, 10 cycles busy) → bytes 0x41 0x42 0x20 0x33 0x46 0x0D 0x0A; exactly 7 strobes, one `done`.
- NIBBLES=4, GROUP=0, EOL=0, value=0x0009 → 0x30 0x30 0x30 0x39; no space/CR/LF; `done` after the 4th acknowledgement.
- NIBBLES=5, GROUP=2, EOL=2, value=0x1C0DE → 0x0D 0x0A 0x31 0x20 0x43 0x30 0x20 0x44 0x45.
- Pulse `go` with value=0x1234 and again mid-frame with value=0xFFFF → only "12 34\r\n" sent. A `go` in the `done` cycle with 0x5678 → immediately followed by "56 78\r\n".
- Assert `rst` after the 3rd strobe → next cycle `busy`=0, `tx_start`=0, `tx_buf`=0x00, no `done`. The next `go` sends a complete, correct frame.
- Hold `tx_ready`=0 for 50 cycles after `go` → no strobe, `busy` stays 1. Release → first strobe within 1 cycle.
